// File: rtl/subtractor_serial_nbit_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// FSM state encoding and the bit-counter width function.
package subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Counter must index bits 0..w-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/subtractor_serial_nbit_1bit.sv
// Single-bit full subtractor: Diff = A - B - Bin with borrow out.
module subtractor_1bit (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic Diff,
   output logic Bout
);

   assign Diff = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/subtractor_serial_nbit.sv
// Bit-serial unsigned subtractor, Diff = A - B mod 2^WIDTH, LSB first.
// Operands accepted in IDLE, WIDTH RUN cycles, result held in DONE
// until out_ready. Optional Borrow output when SUB_BORROW_OUT_EN is defined.
module subtractor_serial_nbit
   import subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff
`ifdef SUB_BORROW_OUT_EN
   ,
   output logic             Borrow
`endif
);

   localparam int unsigned      CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   diff_sr_q, diff_sr_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               borrow_q, borrow_d;
   logic               bit_diff;
   logic               bit_bout;
   logic [WIDTH:0]     diff_cat;

   subtractor_1bit u_bit (
      .A    (a_sr_q[0]),
      .B    (b_sr_q[0]),
      .Bin  (borrow_q),
      .Diff (bit_diff),
      .Bout (bit_bout)
   );

   // New result bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
   assign diff_cat = {bit_diff, diff_sr_q} >> 1;

   // Next-state and handshake outputs of the control FSM.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (bit_cnt_q == LAST_BIT) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state: load on accept, shift one bit per RUN cycle, hold otherwise.
   always_comb begin
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      diff_sr_d = diff_sr_q;
      bit_cnt_d = bit_cnt_q;
      borrow_d  = borrow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d    = A;
               b_sr_d    = B;
               borrow_d  = 1'b0;
               bit_cnt_d = '0;
            end
         end
         RUN: begin
            a_sr_d    = a_sr_q >> 1;
            b_sr_d    = b_sr_q >> 1;
            diff_sr_d = diff_cat[WIDTH-1:0];
            borrow_d  = bit_bout;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         diff_sr_q <= '0;
         bit_cnt_q <= '0;
         borrow_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         diff_sr_q <= diff_sr_d;
         bit_cnt_q <= bit_cnt_d;
         borrow_q  <= borrow_d;
      end
   end

   assign Diff = diff_sr_q;
`ifdef SUB_BORROW_OUT_EN
   assign Borrow = borrow_q;
`endif

endmodule

// File: tb/tb_subtractor_serial_nbit.sv
// Bench for subtractor_serial_nbit: directed WIDTH=8 scenarios plus
// randomized WIDTH=1 and WIDTH=32 operations against an arithmetic model.
module tb_subtractor_serial_nbit;

   logic clk = 1'b0;
   logic rst_n;

   logic        v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready;
   logic [7:0]  v8_A, v8_B, v8_Diff;
   logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready;
   logic [0:0]  v1_A, v1_B, v1_Diff;
   logic        v32_in_valid, v32_in_ready, v32_out_valid, v32_out_ready;
   logic [31:0] v32_A, v32_B, v32_Diff;
`ifdef SUB_BORROW_OUT_EN
   logic        v8_Borrow, v1_Borrow, v32_Borrow;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   subtractor_serial_nbit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v8_in_valid), .in_ready(v8_in_ready),
      .A(v8_A), .B(v8_B),
      .out_valid(v8_out_valid), .out_ready(v8_out_ready),
      .Diff(v8_Diff)
`ifdef SUB_BORROW_OUT_EN
      , .Borrow(v8_Borrow)
`endif
   );

   subtractor_serial_nbit #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v1_in_valid), .in_ready(v1_in_ready),
      .A(v1_A), .B(v1_B),
      .out_valid(v1_out_valid), .out_ready(v1_out_ready),
      .Diff(v1_Diff)
`ifdef SUB_BORROW_OUT_EN
      , .Borrow(v1_Borrow)
`endif
   );

   subtractor_serial_nbit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v32_in_valid), .in_ready(v32_in_ready),
      .A(v32_A), .B(v32_B),
      .out_valid(v32_out_valid), .out_ready(v32_out_ready),
      .Diff(v32_Diff)
`ifdef SUB_BORROW_OUT_EN
      , .Borrow(v32_Borrow)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation from IDLE up to the first cycle out_valid is seen.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
      logic [7:0] ed;
      logic       eb;
      int         cnt;
      ed = a - b;
      eb = (a < b);
      chk({tag, ".idle_rdy"}, 64'(v8_in_ready), 64'd1);
      v8_in_valid = 1'b1;
      v8_A = a;
      v8_B = b;
      @(negedge clk);
      v8_in_valid = 1'b0;
      v8_A = 8'($urandom);
      v8_B = 8'($urandom);
      chk({tag, ".run_rdy"}, 64'(v8_in_ready), 64'd0);
      cnt = 0;
      while (v8_out_valid !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, ".latency"}, 64'(cnt), 64'd8);
      chk({tag, ".diff"}, 64'(v8_Diff), 64'(ed));
`ifdef SUB_BORROW_OUT_EN
      chk({tag, ".borrow"}, 64'(v8_Borrow), 64'(eb));
`endif
   endtask

   logic [7:0]  held, pa[3], pb[3], ea8;
   logic [8:0]  expq[$];
   logic [8:0]  e9;
   int          acc_cyc[$];
   int          cyc, nacc, nres, cnt;
   logic [31:0] a32, b32, e32;
   logic [0:0]  a1, b1, e1;

   initial begin
      rst_n = 1'b0;
      v8_in_valid = 1'b0;  v8_out_ready = 1'b1;  v8_A = '0;  v8_B = '0;
      v1_in_valid = 1'b0;  v1_out_ready = 1'b1;  v1_A = '0;  v1_B = '0;
      v32_in_valid = 1'b0; v32_out_ready = 1'b1; v32_A = '0; v32_B = '0;
      repeat (2) @(negedge clk);

      chk("rst.in_ready", 64'(v8_in_ready), 64'd1);
      chk("rst.out_valid", 64'(v8_out_valid), 64'd0);
      chk("rst.diff", 64'(v8_Diff), 64'd0);
`ifdef SUB_BORROW_OUT_EN
      chk("rst.borrow", 64'(v8_Borrow), 64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      op8(8'h5A, 8'h23, "basic");
      chk("basic.const", 64'(v8_Diff), 64'h37);
      @(negedge clk);
      chk("basic.rdy_after", 64'(v8_in_ready), 64'd1);
      chk("basic.vld_after", 64'(v8_out_valid), 64'd0);

      op8(8'h00, 8'h01, "uflow1");
      chk("uflow1.const", 64'(v8_Diff), 64'hFF);
      @(negedge clk);
      op8(8'h10, 8'h80, "uflow2");
      chk("uflow2.const", 64'(v8_Diff), 64'h90);
      @(negedge clk);

      // Backpressure: DONE held for 5 cycles.
      v8_out_ready = 1'b0;
      op8(8'hC3, 8'h3C, "bp");
      held = v8_Diff;
      repeat (5) begin
         @(negedge clk);
         chk("bp.vld_hold", 64'(v8_out_valid), 64'd1);
         chk("bp.diff_hold", 64'(v8_Diff), 64'(held));
         chk("bp.rdy_hold", 64'(v8_in_ready), 64'd0);
      end
      v8_out_ready = 1'b1;
      @(negedge clk);
      chk("bp.rdy_after", 64'(v8_in_ready), 64'd1);
      chk("bp.vld_after", 64'(v8_out_valid), 64'd0);
      chk("bp.diff_kept", 64'(v8_Diff), 64'(held));

      // Back-to-back with in_valid held high, operands disturbed during RUN.
      pa[0] = 8'h9C; pb[0] = 8'h2B;
      pa[1] = 8'h01; pb[1] = 8'hFE;
      pa[2] = 8'hF0; pb[2] = 8'h0F;
      v8_A = pa[0]; v8_B = pb[0]; v8_in_valid = 1'b1;
      cyc = 0; nacc = 0; nres = 0;
      while ((nacc < 3 || nres < 3) && cyc < 200) begin
         if (v8_out_valid === 1'b1) begin
            if (expq.size() > 0) begin
               e9 = expq.pop_front();
               chk("b2b.diff", 64'(v8_Diff), 64'(e9[7:0]));
`ifdef SUB_BORROW_OUT_EN
               chk("b2b.borrow", 64'(v8_Borrow), 64'(e9[8]));
`endif
            end
            nres++;
            if (nacc < 3) begin
               v8_A = pa[nacc];
               v8_B = pb[nacc];
            end
         end else if (v8_in_ready === 1'b1 && v8_in_valid === 1'b1) begin
            ea8 = v8_A - v8_B;
            expq.push_back({(v8_A < v8_B), ea8});
            acc_cyc.push_back(cyc);
            nacc++;
         end else begin
            if (nacc >= 3) v8_in_valid = 1'b0;
            v8_A = 8'($urandom);
            v8_B = 8'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      v8_in_valid = 1'b0;
      chk("b2b.accepts", 64'(nacc), 64'd3);
      chk("b2b.results", 64'(nres), 64'd3);
      if (acc_cyc.size() == 3) begin
         chk("b2b.space1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd10);
         chk("b2b.space2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd10);
      end

      // Reset at bit 4 of a running operation.
      v8_A = 8'h77; v8_B = 8'h12; v8_in_valid = 1'b1;
      @(negedge clk);
      v8_in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst.in_ready", 64'(v8_in_ready), 64'd1);
      chk("midrst.out_valid", 64'(v8_out_valid), 64'd0);
      chk("midrst.diff", 64'(v8_Diff), 64'd0);
`ifdef SUB_BORROW_OUT_EN
      chk("midrst.borrow", 64'(v8_Borrow), 64'd0);
`endif
      @(negedge clk);
      chk("midrst.no_vld", 64'(v8_out_valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      op8(8'hFF, 8'hFF, "postrst");
      chk("postrst.const", 64'(v8_Diff), 64'h00);
      @(negedge clk);

      // Random WIDTH=8 operations.
      for (int n = 0; n < 50; n++) begin
         op8(8'($urandom), 8'($urandom), "rnd8");
         @(negedge clk);
      end

      // Random WIDTH=1 operations.
      for (int n = 0; n < 1000; n++) begin
         a1 = 1'($urandom_range(0, 1));
         b1 = 1'($urandom_range(0, 1));
         e1 = a1 - b1;
         v1_in_valid = 1'b1; v1_A = a1; v1_B = b1;
         @(negedge clk);
         v1_in_valid = 1'b0; v1_A = 1'($urandom); v1_B = 1'($urandom);
         cnt = 0;
         while (v1_out_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
         end
         chk("w1.latency", 64'(cnt), 64'd1);
         chk("w1.diff", 64'(v1_Diff), 64'(e1));
`ifdef SUB_BORROW_OUT_EN
         chk("w1.borrow", 64'(v1_Borrow), 64'(a1 < b1));
`endif
         @(negedge clk);
      end

      // Random WIDTH=32 operations.
      for (int n = 0; n < 1000; n++) begin
         a32 = $urandom;
         b32 = $urandom;
         if (n == 0) begin a32 = 32'h0; b32 = 32'h1; end
         if (n == 1) begin a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; end
         e32 = a32 - b32;
         v32_in_valid = 1'b1; v32_A = a32; v32_B = b32;
         @(negedge clk);
         v32_in_valid = 1'b0; v32_A = $urandom; v32_B = $urandom;
         cnt = 0;
         while (v32_out_valid !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
         end
         chk("w32.latency", 64'(cnt), 64'd32);
         chk("w32.diff", 64'(v32_Diff), 64'(e32));
`ifdef SUB_BORROW_OUT_EN
         chk("w32.borrow", 64'(v32_Borrow), 64'(a32 < b32));
`endif
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
